// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the 12-bit colour type used by the
// timing generator and the upstream rgb mux.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    function automatic int unsigned span_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    localparam color_t COLOR_BLACK = '0;

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register with synchronous clear; DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else if (clr) begin
                for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else if (ce) begin
                stage[0] <= d;
                for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, h/v counters and sync/colour output stage for the
// VGA pins, with sync and blanking delayed to match upstream colour latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned PIPE     = 1,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        p_tick,
    output logic        frame_tick,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_IDLE = ~SYNC_POL;

    logic [DIV_W-1:0] div;
    logic             tick_q;
    logic [9:0]       h;
    logic [9:0]       v;
    logic             line_end;
    logic             frame_end;
    logic             hsync_raw;
    logic             vsync_raw;
    logic [2:0]       dl_d;
    logic [2:0]       dl_q;
    logic             video_on_d;
    logic             hsync_d;
    logic             vsync_d;
    color_t           rgb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            tick_q <= 1'b0;
        end else if (!en) begin
            div    <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    // Gating with en keeps the strobe low in the clk en falls, before the clear lands.
    assign p_tick = tick_q & en;

    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (!en) begin
            h <= '0;
            v <= '0;
        end else if (p_tick) begin
            if (line_end) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // One-clk pulse in the same clk as the wrap, replacing the old (0,0) level tick.
    assign frame_tick = p_tick && frame_end;

    assign pixel_x  = h;
    assign pixel_y  = v;
    assign video_on = en && (h < H_ACT) && (v < V_ACT);

    assign hsync_raw = (h >= HS_FIRST) && (h <= HS_LAST);
    assign vsync_raw = (v >= VS_FIRST) && (v <= VS_LAST);

    assign dl_d = {video_on, hsync_raw, vsync_raw};

    vga_delay_line #(
        .DEPTH (PIPE),
        .WIDTH (3)
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (p_tick),
        .clr   (~en),
        .d     (dl_d),
        .q     (dl_q)
    );

    assign {video_on_d, hsync_d, vsync_d} = dl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs    <= SYNC_IDLE;
            vs    <= SYNC_IDLE;
            rgb_q <= COLOR_BLACK;
        end else if (!en) begin
            hs    <= SYNC_IDLE;
            vs    <= SYNC_IDLE;
            rgb_q <= COLOR_BLACK;
        end else if (p_tick) begin
            hs    <= SYNC_POL ? hsync_d : ~hsync_d;
            vs    <= SYNC_POL ? vsync_d : ~vsync_d;
            rgb_q <= video_on_d ? color_t'(rgb_in) : COLOR_BLACK;
        end
    end

    assign r = rgb_q.r;
    assign g = rgb_q.g;
    assign b = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 24x10 raster, with PIPE 0/1/3
// instances in lockstep and a CLK_DIV=1 instance alongside.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HSY = 4, HB = 2;
    localparam int VA = 6,  VF = 1, VSY = 2, VB = 1;
    localparam int HT = 24, VT = 10;
    localparam int TMO = 4000;

    logic clk = 1'b0;
    logic reset;
    logic en;

    int n_cmp = 0;
    int n_bad = 0;

    // a: PIPE=1, z: PIPE=0, c: PIPE=3 (all CLK_DIV=4); f: CLK_DIV=1, PIPE=1
    logic [9:0]  px_a, py_a, px_z, py_z, px_c, py_c, px_f, py_f;
    logic        von_a, pt_a, ft_a, hs_a, vs_a;
    logic        von_z, pt_z, ft_z, hs_z, vs_z;
    logic        von_c, pt_c, ft_c, hs_c, vs_c;
    logic        von_f, pt_f, ft_f, hs_f, vs_f;
    logic [3:0]  r_a, g_a, b_a, r_z, g_z, b_z, r_c, g_c, b_c, r_f, g_f, b_f;
    logic [11:0] rgb_a, rgb_z, rgb_c, rgb_f;
    logic [11:0] pin_a, pin_z, pin_c, pin_f;

    always #5 clk = ~clk;

    // Colour source: F0A for pixels that were active PIPE ticks ago, FFF otherwise.
    function automatic logic [11:0] src(input logic [9:0] x, input logic [9:0] y, input int pipe);
        if ((int'(x) >= pipe) && (int'(x) - pipe < HA) && (int'(y) < VA)) return 12'hF0A;
        return 12'hFFF;
    endfunction

    assign rgb_a = src(px_a, py_a, 1);
    assign rgb_z = src(px_z, py_z, 0);
    assign rgb_c = src(px_c, py_c, 3);
    assign rgb_f = src(px_f, py_f, 1);

    assign pin_a = {r_a, g_a, b_a};
    assign pin_z = {r_z, g_z, b_z};
    assign pin_c = {r_c, g_c, b_c};
    assign pin_f = {r_f, g_f, b_f};

    vga_timing_gen #(
        .CLK_DIV(4), .PIPE(1),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_a),
        .pixel_x(px_a), .pixel_y(py_a), .video_on(von_a), .p_tick(pt_a),
        .frame_tick(ft_a), .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .PIPE(0),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut_z (
        .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_z),
        .pixel_x(px_z), .pixel_y(py_z), .video_on(von_z), .p_tick(pt_z),
        .frame_tick(ft_z), .hs(hs_z), .vs(vs_z), .r(r_z), .g(g_z), .b(b_z)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .PIPE(3),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut_c (
        .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_c),
        .pixel_x(px_c), .pixel_y(py_c), .video_on(von_c), .p_tick(pt_c),
        .frame_tick(ft_c), .hs(hs_c), .vs(vs_c), .r(r_c), .g(g_c), .b(b_c)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .PIPE(1),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut_f (
        .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_f),
        .pixel_x(px_f), .pixel_y(py_f), .video_on(von_f), .p_tick(pt_f),
        .frame_tick(ft_f), .hs(hs_f), .vs(vs_f), .r(r_f), .g(g_f), .b(b_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the first falling edge at which dut_a reads (x,y).
    task automatic wait_xy(input int x, input int y);
        int n;
        n = 0;
        @(negedge clk);
        while (!(int'(px_a) == x && int'(py_a) == y) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_%0d_%0d", x, y), (n < TMO), 1);
    endtask

    typedef struct {
        int          x;
        logic [11:0] rgb_a, rgb_z, rgb_c;
        logic        hs_a, hs_z, hs_c;
    } pt_vec_t;

    // Line y=2: pins at counter x show pixel x-PIPE-1; raw hsync is h=18..21.
    pt_vec_t line_vec [13] = '{
        '{ 0, 12'h000, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0},
        '{ 1, 12'h000, 12'hF0A, 12'h000, 1'b1, 1'b1, 1'b0},
        '{ 2, 12'hF0A, 12'hF0A, 12'h000, 1'b1, 1'b1, 1'b1},
        '{ 3, 12'hF0A, 12'hF0A, 12'h000, 1'b1, 1'b1, 1'b1},
        '{ 4, 12'hF0A, 12'hF0A, 12'hF0A, 1'b1, 1'b1, 1'b1},
        '{16, 12'hF0A, 12'hF0A, 12'hF0A, 1'b1, 1'b1, 1'b1},
        '{17, 12'hF0A, 12'h000, 12'hF0A, 1'b1, 1'b1, 1'b1},
        '{18, 12'h000, 12'h000, 12'hF0A, 1'b1, 1'b1, 1'b1},
        '{19, 12'h000, 12'h000, 12'hF0A, 1'b1, 1'b0, 1'b1},
        '{20, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1},
        '{21, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1},
        '{22, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0},
        '{23, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0}
    };

    initial begin
        int n;
        int cnt;
        int cnt2;

        reset = 1'b1;
        en    = 1'b1;

        // Reset state
        #3;
        chk("rst_px", px_a, 0);
        chk("rst_py", py_a, 0);
        chk("rst_ptick", pt_a, 0);
        chk("rst_ftick", ft_a, 0);
        chk("rst_video_on", von_a, 1);
        chk("rst_hs", hs_a, 1);
        chk("rst_vs", vs_a, 1);
        chk("rst_rgb", pin_a, 0);
        chk("rst_ptick_f", pt_f, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // First p_tick CLK_DIV clks after reset release
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("first_tick_%0d", k), pt_a, (k == 4));
            if (k == 1) chk("first_tick_f", pt_f, 1);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pt_a !== 1'b1 && n < 20);
        chk("tick_period", n, 4);

        // Pin alignment across PIPE 0/1/3 on one active line
        for (int i = 0; i < 13; i++) begin
            wait_xy(line_vec[i].x, 2);
            chk($sformatf("rgb_p1_x%0d", line_vec[i].x), pin_a, line_vec[i].rgb_a);
            chk($sformatf("rgb_p0_x%0d", line_vec[i].x), pin_z, line_vec[i].rgb_z);
            chk($sformatf("rgb_p3_x%0d", line_vec[i].x), pin_c, line_vec[i].rgb_c);
            chk($sformatf("hs_p1_x%0d", line_vec[i].x), hs_a, line_vec[i].hs_a);
            chk($sformatf("hs_p0_x%0d", line_vec[i].x), hs_z, line_vec[i].hs_z);
            chk($sformatf("hs_p3_x%0d", line_vec[i].x), hs_c, line_vec[i].hs_c);
        end

        // One full line: 24 ticks, hs low for exactly 4 of them
        wait_xy(0, 3);
        cnt  = 0;
        cnt2 = 0;
        for (int i = 0; i < HT * 4; i++) begin
            if (pt_a === 1'b1) begin
                cnt2++;
                if (hs_a === 1'b0) cnt++;
            end
            @(negedge clk);
        end
        chk("line_ticks", cnt2, HT);
        chk("hs_low_ticks", cnt, HSY);

        // Frame period, vs low for 2 lines, frame_tick one clk wide
        n = 0;
        while (ft_a !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("frame_tick_seen", (n < TMO), 1);
        n   = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("frame_tick_width", ft_a, 0);
            if (pt_a === 1'b1 && vs_a === 1'b0) cnt++;
        end while (ft_a !== 1'b1 && n < TMO);
        chk("frame_period", n, HT * VT * 4);
        chk("vs_low_ticks", cnt, VSY * HT);

        // Boundary at (23,9)
        wait_xy(HT - 1, VT - 1);
        chk("bnd_pre_ptick", pt_a, 0);
        chk("bnd_pre_ftick", ft_a, 0);
        repeat (3) @(negedge clk);
        chk("bnd_ptick", pt_a, 1);
        chk("bnd_ftick", ft_a, 1);
        chk("bnd_px", px_a, HT - 1);
        @(negedge clk);
        chk("wrap_px", px_a, 0);
        chk("wrap_py", py_a, 0);
        chk("wrap_ftick", ft_a, 0);

        // CLK_DIV=1: p_tick held high, line 24 clk, frame 240 clk, 1-clk frame_tick
        n = 0;
        while (px_f !== 10'd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("f_line_sync", (n < 100), 1);
        n   = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (pt_f !== 1'b1) cnt++;
        end while (px_f !== 10'd0 && n < 100);
        chk("f_line_period", n, HT);
        chk("f_ptick_low", cnt, 0);
        n = 0;
        while (ft_f !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("f_frame_tick_seen", (n < 500), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("f_frame_tick_width", ft_f, 0);
        end while (ft_f !== 1'b1 && n < 500);
        chk("f_frame_period", n, HT * VT);

        // en low in the middle of hsync/vsync for 50 clk
        wait_xy(21, 7);
        chk("pre_en_hs", hs_a, 0);
        chk("pre_en_vs", vs_a, 0);
        en = 1'b0;
        #1;
        chk("en_low_ptick", pt_a, 0);
        chk("en_low_video_on", von_a, 0);
        @(negedge clk);
        chk("en_low_hs", hs_a, 1);
        chk("en_low_vs", vs_a, 1);
        chk("en_low_px", px_a, 0);
        chk("en_low_py", py_a, 0);
        cnt = 0;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            if (hs_a !== 1'b1 || vs_a !== 1'b1 || pin_a !== 12'h000 || pt_a !== 1'b0 ||
                ft_a !== 1'b0 || von_a !== 1'b0 || px_a !== 10'd0 || py_a !== 10'd0 ||
                pt_f !== 1'b0 || hs_c !== 1'b1 || pin_c !== 12'h000) cnt++;
        end
        chk("en_low_hold", cnt, 0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("en_restart_tick_%0d", k), pt_a, (k == 4));
            chk($sformatf("en_restart_pos_%0d", k), {px_a, py_a}, 20'd0);
        end
        @(negedge clk);
        chk("en_restart_px1", px_a, 1);

        // Asynchronous reset mid-hsync
        wait_xy(21, 2);
        chk("pre_rst_hs", hs_a, 0);
        chk("pre_rst_hs_p0", hs_z, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_hs", hs_a, 1);
        chk("async_rst_hs_p0", hs_z, 1);
        chk("async_rst_px", px_a, 0);
        chk("async_rst_py", py_a, 0);
        chk("async_rst_rgb", pin_a, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_restart_tick_%0d", k), pt_a, (k == 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
